// File: rtl/cmat_codebook_mac.sv
// Streams H*S_q for every codebook matrix S_q, one complex result per KDIM cycles.
// Codebook entries are 3-bit codes in {0, +-x/2, +-j*x/2}, applied by shifts and adds.
module cmat_codebook_mac #(
    parameter int N         = 16,
    parameter int Q         = 8,
    parameter int ROWS      = 4,
    parameter int KDIM      = 4,
    parameter int COLS      = 2,
    parameter int NUM_Q     = 16,
    parameter int ACC_WIDTH = N + 4,
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int JW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int KW = (KDIM > 1) ? $clog2(KDIM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  h_in_r,
    input  logic [N-1:0]  h_in_i,
    output logic [QW-1:0] coef_q,
    output logic [KW-1:0] coef_k,
    output logic [JW-1:0] coef_j,
    input  logic [2:0]    coef_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  hq_out_r,
    output logic [N-1:0]  hq_out_i,
    output logic [QW-1:0] out_q,
    output logic [IW-1:0] out_i,
    output logic [JW-1:0] out_j,
    output logic          one_done,
    output logic          all_done
);
    localparam int HSIZE = ROWS * KDIM;
    localparam int LW    = (HSIZE > 1) ? $clog2(HSIZE) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-N+1){1'b1}}, {(N-1){1'b0}}};

    generate
        if (ACC_WIDTH < N + $clog2(KDIM) || Q >= N) begin : g_bad_params
            $error("cmat_codebook_mac: ACC_WIDTH too small or Q out of range");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_FINISH} state_t;
    state_t state_reg, state_next;

    logic [LW-1:0] ld_idx_reg;
    logic [QW-1:0] q_reg;
    logic [IW-1:0] i_reg;
    logic [JW-1:0] j_reg;
    logic [KW-1:0] k_reg;
    logic          issue_done_reg;
    logic signed [ACC_WIDTH-1:0] acc_r_reg, acc_i_reg;

    // Completed, saturated result waiting for the output register; lets the
    // next result accumulate while the output is back-pressured.
    logic          pend_valid_reg;
    logic [N-1:0]  pend_r_reg, pend_i_reg;
    logic [QW-1:0] pend_q_reg;
    logic [IW-1:0] pend_row_reg;
    logic [JW-1:0] pend_col_reg;

    logic          out_valid_reg;
    logic [N-1:0]  out_r_reg, out_im_reg;
    logic [QW-1:0] out_q_reg;
    logic [IW-1:0] out_i_reg;
    logic [JW-1:0] out_j_reg;

    logic [N-1:0] h_r_mem [HSIZE];
    logic [N-1:0] h_i_mem [HSIZE];

    logic load_fire, k_last, j_last, i_last, q_last;
    logic out_free, pend_move, issue, pend_load, out_fire;
    logic [LW-1:0] rd_idx;
    logic signed [ACC_WIDTH-1:0] xr_ext, xi_ext, half_r, half_i;
    logic signed [ACC_WIDTH-1:0] term_r, term_i, sum_r, sum_i;

    function automatic logic [N-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            saturate = SAT_MAX[N-1:0];
        else if (v < SAT_MIN)
            saturate = SAT_MIN[N-1:0];
        else
            saturate = v[N-1:0];
    endfunction

    assign load_fire = (state_reg == S_LOAD) && in_valid;
    assign in_ready  = (state_reg == S_LOAD);

    always_ff @(posedge clk) begin
        if (load_fire) begin
            h_r_mem[ld_idx_reg] <= h_in_r;
            h_i_mem[ld_idx_reg] <= h_in_i;
        end
    end

    assign rd_idx = LW'(LW'(i_reg) * LW'(KDIM)) + LW'(k_reg);
    assign xr_ext = ACC_WIDTH'($signed(h_r_mem[rd_idx]));
    assign xi_ext = ACC_WIDTH'($signed(h_i_mem[rd_idx]));
    assign half_r = xr_ext >>> 1;
    assign half_i = xi_ext >>> 1;

    // Negative codes negate the already-halved value.
    always_comb begin
        term_r = '0;
        term_i = '0;
        case (coef_code)
            3'd1: begin term_r = half_r;  term_i = half_i;  end
            3'd2: begin term_r = -half_r; term_i = -half_i; end
            3'd3: begin term_r = -half_i; term_i = half_r;  end
            3'd4: begin term_r = half_i;  term_i = -half_r; end
            default: ;
        endcase
    end

    assign sum_r = (k_reg == '0) ? term_r : acc_r_reg + term_r;
    assign sum_i = (k_reg == '0) ? term_i : acc_i_reg + term_i;

    assign k_last    = (k_reg == KW'(KDIM - 1));
    assign j_last    = (j_reg == JW'(COLS - 1));
    assign i_last    = (i_reg == IW'(ROWS - 1));
    assign q_last    = (q_reg == QW'(NUM_Q - 1));
    assign out_free  = !out_valid_reg || out_ready;
    assign pend_move = pend_valid_reg && out_free;
    assign issue     = (state_reg == S_CALC) && !issue_done_reg
                       && !(k_last && pend_valid_reg && !out_free);
    assign pend_load = issue && k_last;
    assign out_fire  = out_valid_reg && out_ready;
    assign one_done  = out_fire && (out_i_reg == IW'(ROWS - 1)) && (out_j_reg == JW'(COLS - 1));
    assign all_done  = one_done && (out_q_reg == QW'(NUM_Q - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   if (load_fire && ld_idx_reg == LW'(HSIZE - 1)) state_next = S_CALC;
            S_CALC:   if (all_done) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            ld_idx_reg     <= '0;
            q_reg          <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            issue_done_reg <= 1'b0;
            acc_r_reg      <= '0;
            acc_i_reg      <= '0;
            pend_valid_reg <= 1'b0;
            pend_r_reg     <= '0;
            pend_i_reg     <= '0;
            pend_q_reg     <= '0;
            pend_row_reg   <= '0;
            pend_col_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_r_reg      <= '0;
            out_im_reg     <= '0;
            out_q_reg      <= '0;
            out_i_reg      <= '0;
            out_j_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (load_fire)
                ld_idx_reg <= (ld_idx_reg == LW'(HSIZE - 1)) ? '0 : ld_idx_reg + LW'(1);
            if (issue) begin
                acc_r_reg <= sum_r;
                acc_i_reg <= sum_i;
                k_reg     <= k_last ? '0 : k_reg + KW'(1);
                if (k_last) begin
                    j_reg <= j_last ? '0 : j_reg + JW'(1);
                    if (j_last) begin
                        i_reg <= i_last ? '0 : i_reg + IW'(1);
                        if (i_last) begin
                            q_reg <= q_last ? '0 : q_reg + QW'(1);
                            if (q_last)
                                issue_done_reg <= 1'b1;
                        end
                    end
                end
            end
            if (state_reg == S_FINISH)
                issue_done_reg <= 1'b0;
            if (pend_load) begin
                pend_valid_reg <= 1'b1;
                pend_r_reg     <= saturate(sum_r);
                pend_i_reg     <= saturate(sum_i);
                pend_q_reg     <= q_reg;
                pend_row_reg   <= i_reg;
                pend_col_reg   <= j_reg;
            end else if (pend_move) begin
                pend_valid_reg <= 1'b0;
            end
            if (out_free) begin
                out_valid_reg <= pend_valid_reg;
                if (pend_valid_reg) begin
                    out_r_reg  <= pend_r_reg;
                    out_im_reg <= pend_i_reg;
                    out_q_reg  <= pend_q_reg;
                    out_i_reg  <= pend_row_reg;
                    out_j_reg  <= pend_col_reg;
                end
            end
        end
    end

    assign coef_q    = q_reg;
    assign coef_k    = k_reg;
    assign coef_j    = j_reg;
    assign out_valid = out_valid_reg;
    assign hq_out_r  = out_r_reg;
    assign hq_out_i  = out_im_reg;
    assign out_q     = out_q_reg;
    assign out_i     = out_i_reg;
    assign out_j     = out_j_reg;
endmodule

// File: tb/tb_cmat_codebook_mac.sv
// Self-checking bench for cmat_codebook_mac: directed vector table, identity job,
// back-pressure, reset and start-abuse sequences, and randomized jobs against a model.
module tb_cmat_codebook_mac;
    localparam int N = 16, Q = 8, ROWS = 4, KDIM = 4, COLS = 2, NUM_Q = 16, ACC_WIDTH = N + 4;
    localparam int HS = ROWS * KDIM;
    localparam int NRES = NUM_Q * ROWS * COLS;
    localparam int NCODE = NUM_Q * KDIM * COLS;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [N-1:0] h_in_r = '0, h_in_i = '0;
    logic in_ready, out_valid, one_done, all_done;
    logic [3:0] coef_q, out_q;
    logic [1:0] coef_k, out_i;
    logic coef_j, out_j;
    logic [2:0] coef_code;
    logic [N-1:0] hq_out_r, hq_out_i;

    cmat_codebook_mac #(.N(N), .Q(Q), .ROWS(ROWS), .KDIM(KDIM), .COLS(COLS),
                        .NUM_Q(NUM_Q), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .h_in_r(h_in_r), .h_in_i(h_in_i), .coef_q(coef_q), .coef_k(coef_k), .coef_j(coef_j),
        .coef_code(coef_code), .out_valid(out_valid), .out_ready(out_ready),
        .hq_out_r(hq_out_r), .hq_out_i(hq_out_i), .out_q(out_q), .out_i(out_i), .out_j(out_j),
        .one_done(one_done), .all_done(all_done));

    always #5 clk = ~clk;

    typedef struct { int q, i, j; logic [N-1:0] r, im; logic od, ad; } res_t;
    typedef struct { logic [15:0] hr, hi; bit fill; logic [2:0] code; logic [15:0] er, ei; } vec_t;

    int h_r[HS], h_i[HS];
    logic [2:0] code_tbl[NCODE];
    res_t got[$];
    res_t exp_q[$];
    int n_checks = 0, n_errors = 0;
    int one_cnt, all_cnt, latency, gap;

    always_comb coef_code = code_tbl[(int'(coef_q) * KDIM + int'(coef_k)) * COLS + int'(coef_j)];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int half(input int v);
        return (v >= 0) ? v / 2 : -((1 - v) / 2);
    endfunction

    function automatic logic [N-1:0] sat(input int v);
        if (v > (1 << (N - 1)) - 1) return {1'b0, {(N-1){1'b1}}};
        if (v < -(1 << (N - 1))) return {1'b1, {(N-1){1'b0}}};
        return N'(v);
    endfunction

    // Reference: Hq[i][j] = sum_k decode(S_q[k][j], H[i][k]), complex, saturated.
    task automatic build_expected();
        exp_q.delete();
        for (int q = 0; q < NUM_Q; q++)
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    int sr = 0, si = 0;
                    for (int k = 0; k < KDIM; k++) begin
                        int hr = half(h_r[i*KDIM+k]);
                        int hi = half(h_i[i*KDIM+k]);
                        case (code_tbl[(q*KDIM+k)*COLS+j])
                            3'd1: begin sr += hr; si += hi; end
                            3'd2: begin sr -= hr; si -= hi; end
                            3'd3: begin sr -= hi; si += hr; end
                            3'd4: begin sr += hi; si -= hr; end
                            default: ;
                        endcase
                    end
                    exp_q.push_back('{q, i, j, sat(sr), sat(si),
                                      (i == ROWS-1 && j == COLS-1),
                                      (i == ROWS-1 && j == COLS-1 && q == NUM_Q-1)});
                end
    endtask

    task automatic fill_random();
        for (int e = 0; e < HS; e++) begin
            h_r[e] = int'($urandom_range(0, 65535)) - 32768;
            h_i[e] = int'($urandom_range(0, 65535)) - 32768;
        end
        for (int c = 0; c < NCODE; c++) code_tbl[c] = 3'($urandom_range(0, 7));
    endtask

    task automatic load_h(input int gap_at);
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        check("in_ready_load_start", in_ready, 1);
        for (int e = 0; e < HS; e++) begin
            if (e == gap_at) begin
                in_valid = 1'b0; h_in_r = 16'hDEAD; h_in_i = 16'hBEEF;
                for (int g = 0; g < 3; g++) begin
                    if (g == 1) check("in_ready_gap", in_ready, 1);
                    tick();
                end
            end
            in_valid = 1'b1; h_in_r = N'(h_r[e]); h_in_i = N'(h_i[e]);
            tick();
        end
        in_valid = 1'b0;
        check("in_ready_after_load", in_ready, 0);
    endtask

    task automatic collect(input bit stall_first, input bit rand_ready, input int start_calc_at,
                           input bit start_at_done);
        int cyc = 0, stall_left = 10;
        bit done = 0;
        int hs_cyc[$];
        got.delete(); one_cnt = 0; all_cnt = 0; latency = -1; gap = -1;
        while (!done && cyc < 6000) begin
            logic rdy;
            if (stall_first && out_valid && stall_left > 0) rdy = 1'b0;
            else if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'b1;
            out_ready = rdy;
            start = (cyc == start_calc_at) || (start_at_done && out_valid && rdy &&
                     int'(out_q) == NUM_Q-1 && int'(out_i) == ROWS-1 && int'(out_j) == COLS-1);
            #1;
            if (out_valid && latency < 0) latency = cyc;
            if (stall_first && out_valid && stall_left > 0) begin
                check("stall_hold", {out_valid, out_q, out_i, out_j, hq_out_r, hq_out_i},
                      {1'b1, 4'(exp_q[0].q), 2'(exp_q[0].i), 1'(exp_q[0].j), exp_q[0].r, exp_q[0].im});
                stall_left--;
            end
            if (out_valid && out_ready) begin
                got.push_back('{int'(out_q), int'(out_i), int'(out_j), hq_out_r, hq_out_i, one_done, all_done});
                hs_cyc.push_back(cyc);
            end
            if (one_done) one_cnt++;
            if (all_done) begin all_cnt++; done = 1; end
            tick();
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        if (!done) check("job_timeout", done, 1);
        if (hs_cyc.size() >= 2) gap = hs_cyc[1] - hs_cyc[0];
    endtask

    task automatic verify(input string name);
        check({name, "_count"}, got.size(), exp_q.size());
        for (int n = 0; n < got.size() && n < exp_q.size(); n++)
            check($sformatf("%s_res%0d", name, n),
                  {4'(got[n].q), 2'(got[n].i), 1'(got[n].j), got[n].r, got[n].im, got[n].od, got[n].ad},
                  {4'(exp_q[n].q), 2'(exp_q[n].i), 1'(exp_q[n].j), exp_q[n].r, exp_q[n].im, exp_q[n].od, exp_q[n].ad});
        check({name, "_one_done"}, one_cnt, NUM_Q);
        check({name, "_all_done"}, all_cnt, 1);
        check({name, "_latency"}, latency, KDIM + 1);
    endtask

    task automatic run_job(input string name, input int gap_at, input bit stall_first,
                           input bit rand_ready, input int start_calc_at, input bit start_at_done);
        logic ir_finish;
        build_expected();
        load_h(gap_at);
        collect(stall_first, rand_ready, start_calc_at, start_at_done);
        verify(name);
        ir_finish = in_ready;
        tick();
        check({name, "_no_restart"}, {ir_finish, in_ready}, 2'b00);
        $display("job %s: %0d results, latency %0d, handshake gap %0d", name, got.size(), latency, gap);
    endtask

    function automatic logic [63:0] all_outs();
        return {14'd0, out_valid, in_ready, one_done, all_done, hq_out_r, hq_out_i,
                out_q, out_i, out_j, coef_q, coef_k, coef_j};
    endfunction

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h7FFF, 16'h0000, 1'b1, 3'd1, 16'h7FFF, 16'h0000};
        vecs[1] = '{16'h7FFF, 16'h0000, 1'b1, 3'd2, 16'h8000, 16'h0000};
        vecs[2] = '{16'h0100, 16'h0040, 1'b0, 3'd3, 16'hFFE0, 16'h0080};
        vecs[3] = '{16'h0100, 16'h0040, 1'b0, 3'd4, 16'h0020, 16'hFF80};
        vecs[4] = '{16'h0100, 16'h0040, 1'b0, 3'd1, 16'h0080, 16'h0020};
        vecs[5] = '{16'h0100, 16'h0040, 1'b0, 3'd2, 16'hFF80, 16'hFFE0};
        vecs[6] = '{16'h0100, 16'h0040, 1'b0, 3'd7, 16'h0000, 16'h0000};
        vecs[7] = '{16'h8000, 16'h8000, 1'b1, 3'd3, 16'h7FFF, 16'h8000};
        vecs[8] = '{16'h0003, 16'hFFFD, 1'b0, 3'd1, 16'h0001, 16'hFFFE};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_outputs", all_outs(), 64'd0);

        for (int v = 0; v < 9; v++) begin
            for (int e = 0; e < HS; e++) begin h_r[e] = 0; h_i[e] = 0; end
            for (int k = 0; k < KDIM; k++)
                if (vecs[v].fill || k == 0) begin
                    h_r[k] = int'($signed(vecs[v].hr));
                    h_i[k] = int'($signed(vecs[v].hi));
                end
            for (int q = 0; q < NUM_Q; q++)
                for (int k = 0; k < KDIM; k++)
                    for (int j = 0; j < COLS; j++)
                        code_tbl[(q*KDIM+k)*COLS+j] = (vecs[v].fill || k == 0) ? vecs[v].code : 3'd0;
            run_job($sformatf("vec%0d", v), -1, 1'b0, 1'b0, -1, 1'b0);
            if (got.size() > 0)
                check($sformatf("vec%0d_first", v), {got[0].r, got[0].im}, {vecs[v].er, vecs[v].ei});
        end

        for (int e = 0; e < HS; e++) begin
            h_r[e] = (e / KDIM == e % KDIM) ? 32'h100 : 0;
            h_i[e] = 0;
        end
        for (int c = 0; c < NCODE; c++) code_tbl[c] = 3'd1;
        run_job("identity", -1, 1'b0, 1'b0, -1, 1'b0);
        check("identity_gap", gap, KDIM);
        foreach (got[n]) check("identity_val", {got[n].r, got[n].im}, {16'h0080, 16'h0000});

        fill_random();
        run_job("stall_gap_start", 5, 1'b1, 1'b0, 20, 1'b1);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_job($sformatf("random%0d", r), int'($urandom_range(1, HS-1)), 1'b0, 1'b1, 37, 1'b1);
        end

        fill_random();
        load_h(-1);
        out_ready = 1'b1;
        for (int w = 0; w < 2000 && coef_q != 4'd5; w++) tick();
        check("reach_q5", coef_q, 5);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_calc", all_outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_reset", all_outs(), 64'd0);
        fill_random();
        run_job("after_reset", 9, 1'b0, 1'b1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
